game_state_ctrl: RTL and testbench

- Upstream control stage of the snake game. Produces `game_state` and `game_speed`, which the clock-generation block consumes to gate the function clock and to pace the body-move tick.
- Synchronizes and debounces the three player buttons, then edge-detects them.
- Runs the top-level game FSM and accepts collision/goal events from the game logic.

---
 rtl/snake_pkg.sv | 27 ++
 rtl/btn_conditioner.sv | 43 ++++
 rtl/game_state_ctrl.sv | 126 ++++++++++++
 tb/tb_game_state_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared snake-game types: game state and speed encodings used by the control,
// clock-generation and game-logic blocks.
package snake_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        WAIT     = 2'b01,
        PAUSE    = 2'b10,
        END_GAME = 2'b11
    } GAME_STATE;

    typedef enum logic [1:0] {
        NORMAL_SPEED = 2'b00,
        FAST_SPEED   = 2'b01,
        SLOW_SPEED   = 2'b10
    } GAME_SPEED;

    // Speed-select button walks NORMAL -> FAST -> SLOW -> NORMAL.
    function automatic GAME_SPEED next_speed(input GAME_SPEED s);
        case (s)
            NORMAL_SPEED: next_speed = FAST_SPEED;
            FAST_SPEED:   next_speed = SLOW_SPEED;
            default:      next_speed = NORMAL_SPEED;
        endcase
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One player button: 2-flop synchronizer, debounce counter and rising-edge
// detector producing a single-cycle press pulse.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic system_clk,
    input  logic nreset,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge system_clk or negedge nreset) begin
        if (!nreset) begin
            sync        <= 2'b00;
            level       <= 1'b0;
            level_q     <= 1'b0;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync        <= {sync[0], btn_raw};
            level_q     <= level;
            press_pulse <= level & ~level_q;
            // Any sample agreeing with the accepted level restarts the count.
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Snake game top-level control: button conditioning plus the game FSM.
// Define GAME_STATE_CTRL_AUTO_RESTART_EN to leave END_GAME automatically.
module game_state_ctrl
    import snake_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 200000,
    parameter logic [23:0] END_HOLD_CYCLES = 24'd10000000
) (
    input  logic       system_clk,
    input  logic       nreset,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_speed,
    input  logic       collision,
    input  logic       goal_reached,
    output logic [1:0] game_state,
    output logic [1:0] game_speed,
    output logic       restart_pulse,
    output logic       win
);

    logic start_press, pause_press, speed_press;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .system_clk (system_clk),
        .nreset     (nreset),
        .btn_raw    (btn_start),
        .press_pulse(start_press)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
        .system_clk (system_clk),
        .nreset     (nreset),
        .btn_raw    (btn_pause),
        .press_pulse(pause_press)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_speed (
        .system_clk (system_clk),
        .nreset     (nreset),
        .btn_raw    (btn_speed),
        .press_pulse(speed_press)
    );

    GAME_STATE state_q, state_d;
    GAME_SPEED speed_q, speed_d;
    logic      win_q, win_d;
    logic      rp_q, rp_d;
    logic      hold_done;

`ifdef GAME_STATE_CTRL_AUTO_RESTART_EN
    logic [23:0] hold_cnt;

    // Held at zero outside END_GAME so every entry starts a fresh dwell.
    always_ff @(posedge system_clk or negedge nreset) begin
        if (!nreset)
            hold_cnt <= '0;
        else if (state_q != END_GAME)
            hold_cnt <= '0;
        else if (!hold_done)
            hold_cnt <= hold_cnt + 24'd1;
    end

    assign hold_done = (state_q == END_GAME) && (hold_cnt == END_HOLD_CYCLES - 24'd1);
`else
    logic unused_hold;
    assign unused_hold = ^END_HOLD_CYCLES;
    assign hold_done   = 1'b0;
`endif

    always_ff @(posedge system_clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= WAIT;
            speed_q <= NORMAL_SPEED;
            win_q   <= 1'b0;
            rp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            win_q   <= win_d;
            rp_q    <= rp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        win_d   = win_q;
        rp_d    = 1'b0;
        case (state_q)
            WAIT: begin
                if (speed_press) speed_d = next_speed(speed_q);
                if (start_press) state_d = RUN;
            end
            RUN: begin
                // Losing outranks winning, and both outrank a pause.
                if (collision) begin
                    state_d = END_GAME;
                    win_d   = 1'b0;
                end else if (goal_reached) begin
                    state_d = END_GAME;
                    win_d   = 1'b1;
                end else if (pause_press) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_press || start_press) state_d = RUN;
            end
            END_GAME: begin
                if (start_press || hold_done) begin
                    state_d = WAIT;
                    rp_d    = 1'b1;
                    win_d   = 1'b0;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    assign game_state    = state_q;
    assign game_speed    = speed_q;
    assign restart_pulse = rp_q;
    assign win           = win_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed vector table, corner-case
// sequences and random stimulus against a history-window reference model.
module tb_game_state_ctrl;

    localparam int DB   = 4;
    localparam int HOLD = 20;
`ifdef GAME_STATE_CTRL_AUTO_RESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int S_RUN = 0, S_WAIT = 1, S_PAUSE = 2, S_END = 3;
    localparam int OP_START = 0, OP_PAUSE = 1, OP_SPEED = 2, OP_COLL = 3, OP_GOAL = 4;

    logic system_clk = 1'b0;
    logic nreset = 1'b1;
    logic btn_start = 1'b0, btn_pause = 1'b0, btn_speed = 1'b0;
    logic collision = 1'b0, goal_reached = 1'b0;
    logic [1:0] game_state, game_speed;
    logic restart_pulse, win;

    game_state_ctrl #(.DEBOUNCE_CYCLES(DB), .END_HOLD_CYCLES(24'd20)) dut (
        .system_clk   (system_clk),
        .nreset       (nreset),
        .btn_start    (btn_start),
        .btn_pause    (btn_pause),
        .btn_speed    (btn_speed),
        .collision    (collision),
        .goal_reached (goal_reached),
        .game_state   (game_state),
        .game_speed   (game_speed),
        .restart_pulse(restart_pulse),
        .win          (win)
    );

    always #5 system_clk = ~system_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    // Reference model: a button level is accepted once the four raw samples
    // taken 5..2 edges ago all disagree with it; the press reaches the FSM
    // two edges after acceptance.
    int cyc = 0;
    int hist[3][$];
    int acc[3];
    int rise_at[3];
    int m_state, m_speed, m_win, m_rp, m_entry;

    function automatic int raw_btn(input int b);
        case (b)
            0:       raw_btn = int'(btn_start);
            1:       raw_btn = int'(btn_pause);
            default: raw_btn = int'(btn_speed);
        endcase
    endfunction

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btn_start = v;
            1:       btn_pause = v;
            default: btn_speed = v;
        endcase
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            hist[b].delete();
            for (int k = 0; k < 6; k++) hist[b].push_back(0);
            acc[b]     = 0;
            rise_at[b] = -100;
        end
        m_state = S_WAIT; m_speed = 0; m_win = 0; m_rp = 0; m_entry = 0;
    endtask

    task automatic model_edge();
        bit pr[3];
        bit flip;
        cyc++;
        for (int b = 0; b < 3; b++) pr[b] = (rise_at[b] == cyc);
        for (int b = 0; b < 3; b++) begin
            hist[b].push_back(raw_btn(b));
            void'(hist[b].pop_front());
            flip = 1'b1;
            for (int k = 0; k < 4; k++) if (hist[b][k] == acc[b]) flip = 1'b0;
            if (flip) begin
                acc[b] = 1 - acc[b];
                if (acc[b] == 1) rise_at[b] = cyc + 2;
            end
        end
        m_rp = 0;
        case (m_state)
            S_WAIT: begin
                if (pr[2]) m_speed = (m_speed + 1) % 3;
                if (pr[0]) m_state = S_RUN;
            end
            S_RUN: begin
                if (collision)         begin m_state = S_END; m_win = 0; m_entry = cyc; end
                else if (goal_reached) begin m_state = S_END; m_win = 1; m_entry = cyc; end
                else if (pr[1])        m_state = S_PAUSE;
            end
            S_PAUSE: if (pr[0] || pr[1]) m_state = S_RUN;
            default: if (pr[0] || (AUTO && (cyc - m_entry == HOLD))) begin
                m_state = S_WAIT; m_rp = 1; m_win = 0;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge system_clk);
        if (nreset) model_edge();
        @(negedge system_clk);
        chk("model_state", int'(game_state), m_state);
        chk("model_speed", int'(game_speed), m_speed);
        chk("model_win", int'(win), m_win);
        chk("model_restart", int'(restart_pulse), m_rp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        ticks(8);
        set_btn(b, 1'b0);
        ticks(8);
    endtask

    task automatic pulse(input logic c, input logic g);
        collision = c; goal_reached = g;
        tick();
        collision = 1'b0; goal_reached = 1'b0;
        ticks(2);
    endtask

    typedef struct {
        int         op;
        logic [1:0] st;
        logic [1:0] spd;
        logic       w;
    } vec_t;

    vec_t tbl[$];
    int rem[3];

    initial begin
        // Directed vectors starting from PAUSE with speed NORMAL.
        tbl.push_back('{OP_PAUSE, 2'b00, 2'b00, 1'b0});
        tbl.push_back('{OP_COLL,  2'b11, 2'b00, 1'b0});
        tbl.push_back('{OP_START, 2'b01, 2'b00, 1'b0});
        tbl.push_back('{OP_SPEED, 2'b01, 2'b01, 1'b0});
        tbl.push_back('{OP_SPEED, 2'b01, 2'b10, 1'b0});
        tbl.push_back('{OP_SPEED, 2'b01, 2'b00, 1'b0});
        tbl.push_back('{OP_SPEED, 2'b01, 2'b01, 1'b0});
        tbl.push_back('{OP_PAUSE, 2'b01, 2'b01, 1'b0});
        tbl.push_back('{OP_START, 2'b00, 2'b01, 1'b0});
        tbl.push_back('{OP_SPEED, 2'b00, 2'b01, 1'b0});
        tbl.push_back('{OP_START, 2'b00, 2'b01, 1'b0});
        tbl.push_back('{OP_GOAL,  2'b11, 2'b01, 1'b1});
        tbl.push_back('{OP_START, 2'b01, 2'b01, 1'b0});
        tbl.push_back('{OP_START, 2'b00, 2'b01, 1'b0});
        tbl.push_back('{OP_PAUSE, 2'b10, 2'b01, 1'b0});
        tbl.push_back('{OP_COLL,  2'b10, 2'b01, 1'b0});
        tbl.push_back('{OP_GOAL,  2'b10, 2'b01, 1'b0});
        tbl.push_back('{OP_START, 2'b00, 2'b01, 1'b0});

        // Reset values.
        model_reset();
        #1 nreset = 1'b0;
        #11;
        chk("rst_state", int'(game_state), 1);
        chk("rst_speed", int'(game_speed), 0);
        chk("rst_restart", int'(restart_pulse), 0);
        chk("rst_win", int'(win), 0);

        // Start press latency: RUN exactly 8 edges after the raw edge.
        @(negedge system_clk);
        nreset = 1'b1;
        btn_start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 7) chk("lat_wait_at7", int'(game_state), 1);
            if (i == 8) chk("lat_run_at8", int'(game_state), 0);
        end
        btn_start = 1'b0;
        ticks(8);
        chk("lat_speed", int'(game_speed), 0);

        // Bounce rejection, then a clean 6-cycle press.
        for (int i = 0; i < 20; i++) begin
            btn_pause = ((i / 2) % 2 == 0);
            tick();
        end
        btn_pause = 1'b0;
        ticks(6);
        chk("bounce_run", int'(game_state), 0);
        btn_pause = 1'b1;
        ticks(6);
        btn_pause = 1'b0;
        ticks(4);
        chk("steady_pause", int'(game_state), 2);

        for (int v = 0; v < tbl.size(); v++) begin
            case (tbl[v].op)
                OP_START: press(0);
                OP_PAUSE: press(1);
                OP_SPEED: press(2);
                OP_COLL:  pulse(1'b1, 1'b0);
                default:  pulse(1'b0, 1'b1);
            endcase
            chk($sformatf("vec%0d_state", v), int'(game_state), int'(tbl[v].st));
            chk($sformatf("vec%0d_speed", v), int'(game_speed), int'(tbl[v].spd));
            chk($sformatf("vec%0d_win", v), int'(win), int'(tbl[v].w));
        end

        // Collision, goal and pause press in the same cycle while in RUN.
        btn_pause = 1'b1;
        ticks(7);
        collision = 1'b1; goal_reached = 1'b1;
        tick();
        collision = 1'b0; goal_reached = 1'b0;
        btn_pause = 1'b0;
        chk("prio_end", int'(game_state), 3);
        chk("prio_win", int'(win), 0);
        btn_start = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) chk("restart_pre", int'(restart_pulse), 0);
            if (i == 8) begin
                chk("restart_state", int'(game_state), 1);
                chk("restart_pulse", int'(restart_pulse), 1);
                chk("restart_win", int'(win), 0);
            end
        end
        tick();
        chk("restart_one_cycle", int'(restart_pulse), 0);
        btn_start = 1'b0;
        ticks(8);
        chk("restart_speed_kept", int'(game_speed), 1);

        // Win path, then asynchronous reset between clock edges.
        press(0);
        pulse(1'b0, 1'b1);
        chk("win_end", int'(game_state), 3);
        chk("win_flag", int'(win), 1);
        #2 nreset = 1'b0;
        #1;
        chk("arst_state", int'(game_state), 1);
        chk("arst_win", int'(win), 0);
        chk("arst_speed", int'(game_speed), 0);
        model_reset();
        @(negedge system_clk);
        nreset = 1'b1;

        // END_GAME dwell.
        press(0);
        collision = 1'b1;
        tick();
        collision = 1'b0;
        chk("dwell_entry", int'(game_state), 3);
        if (AUTO) begin
            for (int i = 1; i <= 20; i++) begin
                tick();
                if (i == 19) chk("dwell_end19", int'(game_state), 3);
                if (i == 20) begin
                    chk("dwell_wait20", int'(game_state), 1);
                    chk("dwell_restart", int'(restart_pulse), 1);
                end
            end
            tick();
            chk("dwell_restart_clr", int'(restart_pulse), 0);
        end else begin
            ticks(100);
            chk("dwell_stay_end", int'(game_state), 3);
            press(0);
            chk("dwell_exit", int'(game_state), 1);
        end

        // Random buttons (including bounce) and event pulses.
        for (int b = 0; b < 3; b++) rem[b] = $urandom_range(1, 12);
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 3; b++) begin
                if (rem[b] == 0) begin
                    set_btn(b, raw_btn(b) == 0);
                    rem[b] = $urandom_range(1, 12);
                end
                rem[b]--;
            end
            collision    = ($urandom_range(0, 24) == 0);
            goal_reached = ($urandom_range(0, 24) == 0);
            tick();
        end
        collision = 1'b0; goal_reached = 1'b0;
        btn_start = 1'b0; btn_pause = 1'b0; btn_speed = 1'b0;
        ticks(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
